// File: rtl/codificador_7seg.sv
// codificador_7seg
// Captures a settled 7-segment pattern (active-low, asynchronous input) and
// hands the decoded BCD digit to a consumer over a valido/listo handshake.
// A pattern must hold for STABLE_CYCLES consecutive synchronized cycles
// before it is captured. Legal digit patterns are reported once per hold.
// An illegal non-blank pattern raises a one-cycle error pulse.
// The blank pattern (7F) is never captured.
//
// Optional feature: define CODIFICADOR_HISTORIAL_EN to add the historial
// output, a shift register of the last four transferred digits (newest in
// [3:0]). Without the macro the port and its register are absent.
//
// STABLE_CYCLES legal range: 1..255.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | input blank, nothing pending
// SETTLE      | candidate pattern loaded, counting stable cycles
// HOLD        | digit captured, valido=1, waiting for listo
// WAIT_CHANGE | pattern already reported/flagged, waiting for a new pattern

module codificador_7seg #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] segmentos,
    input  logic       listo,
    output logic [3:0] digito,
    output logic       valido,
    output logic       error
`ifdef CODIFICADOR_HISTORIAL_EN
    ,
    output logic [15:0] historial
`endif
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Active-low segment patterns, bit0=a ... bit6=g.
    localparam logic [6:0] PAT_BLANK = 7'h7F;
    localparam logic [6:0] PAT_0     = 7'h40;
    localparam logic [6:0] PAT_1     = 7'h79;
    localparam logic [6:0] PAT_2     = 7'h24;
    localparam logic [6:0] PAT_3     = 7'h30;
    localparam logic [6:0] PAT_4     = 7'h19;
    localparam logic [6:0] PAT_5     = 7'h12;
    localparam logic [6:0] PAT_6     = 7'h02;
    localparam logic [6:0] PAT_7     = 7'h78;
    localparam logic [6:0] PAT_8     = 7'h00;
    localparam logic [6:0] PAT_9     = 7'h18;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD,
        WAIT_CHANGE
    } state_t;

    state_t        state, state_n;
    logic [6:0]    s1, s2;
    logic [6:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    digito_n;
    logic          valido_n;
    logic          error_n;
    logic          xfer;
    logic          blank;
    logic          same;
    logic          cand_legal;
    logic [3:0]    cand_digit;

    // Decode a pattern into {legal, digit}; anything not in the table is illegal.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        logic [4:0] r;
        unique case (pat)
            PAT_0:   r = {1'b1, 4'd0};
            PAT_1:   r = {1'b1, 4'd1};
            PAT_2:   r = {1'b1, 4'd2};
            PAT_3:   r = {1'b1, 4'd3};
            PAT_4:   r = {1'b1, 4'd4};
            PAT_5:   r = {1'b1, 4'd5};
            PAT_6:   r = {1'b1, 4'd6};
            PAT_7:   r = {1'b1, 4'd7};
            PAT_8:   r = {1'b1, 4'd8};
            PAT_9:   r = {1'b1, 4'd9};
            default: r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

    // Two-flop synchronizer for the asynchronous segment bus; idles at blank.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= PAT_BLANK;
            s2 <= PAT_BLANK;
        end else begin
            s1 <= segmentos;
            s2 <= s1;
        end
    end

    // Classification of the synchronized pattern against the candidate.
    always_comb begin
        blank                    = (s2 == PAT_BLANK);
        same                     = (s2 == cand);
        {cand_legal, cand_digit} = decode(cand);
        xfer                     = valido && listo;
    end

    // Next-state and output logic; every path starts from "hold everything".
    always_comb begin
        state_n  = state;
        cand_n   = cand;
        cnt_n    = cnt;
        digito_n = digito;
        valido_n = valido;
        error_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (!blank) begin
                    cand_n  = s2;
                    cnt_n   = '0;
                    state_n = SETTLE;
                end
            end

            SETTLE: begin
                if (blank) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (!same) begin
                    cand_n = s2;
                    cnt_n  = '0;
                end else if (cnt >= CNT_LAST) begin
                    // This cycle completes the stable run: capture on this edge.
                    cnt_n = CNT_MAX;
                    if (cand_legal) begin
                        digito_n = cand_digit;
                        valido_n = 1'b1;
                        state_n  = HOLD;
                    end else begin
                        error_n  = 1'b1;
                        state_n  = WAIT_CHANGE;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end

            HOLD: begin
                // Digit and valido are frozen until the consumer takes them.
                if (xfer) begin
                    valido_n = 1'b0;
                    state_n  = WAIT_CHANGE;
                end
            end

            WAIT_CHANGE: begin
                if (blank) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (!same) begin
                    cand_n  = s2;
                    cnt_n   = '0;
                    state_n = SETTLE;
                end
            end

            default: begin
                cand_n   = PAT_BLANK;
                cnt_n    = '0;
                valido_n = 1'b0;
                state_n  = IDLE;
            end
        endcase
    end

    // State, candidate, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cand   <= PAT_BLANK;
            cnt    <= '0;
            digito <= 4'd0;
            valido <= 1'b0;
            error  <= 1'b0;
        end else begin
            state  <= state_n;
            cand   <= cand_n;
            cnt    <= cnt_n;
            digito <= digito_n;
            valido <= valido_n;
            error  <= error_n;
        end
    end

`ifdef CODIFICADOR_HISTORIAL_EN
    // History of transferred digits, shifted on each accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            historial <= 16'h0000;
        end else if (xfer) begin
            historial <= {historial[11:0], digito};
        end
    end
`endif

endmodule

// File: doc/codificador_7seg.md
CODIFICADOR_7SEG -- requirements
Module: codificador_7seg

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive cycles a synchronized pattern SHALL hold before capture; legal range 1..255.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset; one clock domain, reset is synchronous and active-high.
REQ-004 segmentos  input  7  asynchronous active-low segment bus; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
REQ-005 listo  input  1  consumer ready; a transfer occurs on an edge where valido=1 and listo=1.
REQ-006 digito  output  4  decoded BCD digit 0..9.
REQ-007 valido  output  1  digito holds a captured value awaiting transfer.
REQ-008 error  output  1  one-cycle pulse on capture of an illegal non-blank pattern.
REQ-009 historial  output  16  last four transferred digits, newest in [3:0]; present only under REQ-024.

Function
REQ-010 segmentos SHALL pass through a 2-flop synchronizer; all later logic SHALL use the second flop (s2) only.
REQ-011 Legal patterns (active-low, hex) SHALL map as: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 18->9 (9 without segment d).
REQ-012 Pattern 7F (all segments off) SHALL be treated as blank: it is never captured, it never raises error, and it counts as a change.
REQ-013 Every other pattern SHALL be illegal.
REQ-014 FSM states: IDLE, SETTLE, HOLD, WAIT_CHANGE.
REQ-015 IDLE: a non-blank s2 SHALL load the candidate register, clear the counter and go to SETTLE.
REQ-016 SETTLE: the counter SHALL increment each cycle s2 equals the candidate.
- s2 differs and is non-blank: reload the candidate, clear the counter, stay in SETTLE.
- s2 is blank: go to IDLE.
REQ-017 When the counter reaches STABLE_CYCLES on a legal candidate, the FSM SHALL drive digito and valido=1 on the next edge and go to HOLD.
- Illegal candidate: pulse error=1 for exactly one cycle and go to WAIT_CHANGE.
REQ-018 Latency: with segmentos held constant, valido SHALL rise on the (STABLE_CYCLES+3)th rising edge after the change.
REQ-019 HOLD: digito and valido SHALL remain stable regardless of segmentos until a transfer.
- After a transfer, valido drops on the next edge and the FSM goes to WAIT_CHANGE.
- listo asserted before valido SHALL have no effect.
REQ-020 WAIT_CHANGE: the FSM SHALL stay while s2 equals the captured pattern.
- s2 blank: go to IDLE.
- s2 different and non-blank: behave as IDLE entry, i.e. load the candidate and go to SETTLE.
- A held pattern is reported exactly once.
REQ-021 The counter SHALL saturate at STABLE_CYCLES; its width SHALL be clog2(STABLE_CYCLES+1).

Reset
REQ-022 While rst=1 on an edge, the FSM SHALL enter IDLE and the following SHALL clear to 0: digito, valido, error, counter, historial. The synchronizer and candidate SHALL load 7F.
REQ-023 Reset asserted mid-HOLD SHALL discard the pending digit without a transfer; reset mid-SETTLE SHALL discard the count.

Configuration
REQ-024 With macro CODIFICADOR_HISTORIAL_EN defined:
- Port historial SHALL exist.
- On each transfer, historial SHALL shift left by 4 bits and load digito into [3:0] on the same edge.
REQ-025 With the macro undefined, the port and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-026 Reset, then hold segmentos=30 with listo=1 and STABLE_CYCLES=4 -> valido=1, digito=3 on edge 7 for one cycle; no second report while 30 is held.
REQ-027 Toggle 12/02 every 2 cycles, then hold 02 -> no valido during toggling; digito=6 exactly STABLE_CYCLES+3 edges after the last change.
REQ-028 segmentos=7F for 50 cycles, then 55 held -> no valido; error pulses once for one cycle; no repeat until the pattern changes.
REQ-029 Capture 9 (18) with listo=0 for 10 cycles while segmentos changes to 40 -> digito stays 9 with valido=1. After listo=1, 9 transfers, then 0 is reported after settling.
REQ-030 rst pulsed while valido=1 -> valido=0 and digito=0 next edge; the held digit is never transferred.
REQ-031 With the macro defined, transfer 1,2,3,4,5 in sequence -> historial=16'h2345.
